// File: rtl/w_burst_fifo.sv
// w_burst_fifo: first-word-fall-through buffer for AXI4 W beats, tracking occupancy and resident complete bursts.
// Optional macro WFIFO_STORE_FWD_EN: hold VALID_OUT until a LAST beat (or a full FIFO) is resident.
module w_burst_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [76:0] DATA_IN,
    input  logic        VALID_IN,
    output logic        READY_IN,
    output logic [76:0] DATA_OUT,
    output logic        VALID_OUT,
    input  logic        READY_OUT,
    output logic [AW:0] LEVEL,
    output logic [AW:0] BURST_CNT
);

    logic [76:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] r_burst_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_push_last;
    logic w_pop_last;

    // Extra MSB on each pointer separates full from empty when the indices match.
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign READY_IN    = !w_full;
    assign w_push      = VALID_IN && READY_IN;
    assign w_pop       = VALID_OUT && READY_OUT;
    assign DATA_OUT    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push_last = w_push && DATA_IN[0];
    assign w_pop_last  = w_pop && DATA_OUT[0];

    assign LEVEL       = r_wr_ptr - r_rd_ptr;
    assign BURST_CNT   = r_burst_cnt;

`ifdef WFIFO_STORE_FWD_EN
    logic r_fwd_open;

    // r_fwd_open keeps a released burst flowing after the full term drops, until its LAST leaves or the FIFO drains.
    assign VALID_OUT = !w_empty && ((r_burst_cnt != '0) || w_full || r_fwd_open);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_fwd_open <= 1'b0;
        end else if (w_pop_last) begin
            r_fwd_open <= 1'b0;
        end else if (w_pop && !w_push && (LEVEL == (AW+1)'(1))) begin
            r_fwd_open <= 1'b0;
        end else begin
            r_fwd_open <= VALID_OUT;
        end
    end
`else
    assign VALID_OUT = !w_empty;
`endif

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_last, w_pop_last})
                2'b10:   r_burst_cnt <= r_burst_cnt + 1'b1;
                2'b01:   r_burst_cnt <= r_burst_cnt - 1'b1;
                default: r_burst_cnt <= r_burst_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_w_burst_fifo.sv
// tb_w_burst_fifo: randomized and directed bench for w_burst_fifo with a queue-based reference model and scoreboard.
module tb_w_burst_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [76:0] DATA_IN = '0;
    logic        VALID_IN = 1'b0;
    logic        READY_OUT = 1'b0;
    logic        READY_IN;
    logic [76:0] DATA_OUT;
    logic        VALID_OUT;
    logic [AW:0] LEVEL;
    logic [AW:0] BURST_CNT;

    int n_chk  = 0;
    int n_pass = 0;

    // m_fifo is the reference contents; exp_q is the scoreboard of beats still owed to the slave.
    logic [76:0] m_fifo[$];
    logic [76:0] exp_q[$];

    w_burst_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .DATA_IN   (DATA_IN),
        .VALID_IN  (VALID_IN),
        .READY_IN  (READY_IN),
        .DATA_OUT  (DATA_OUT),
        .VALID_OUT (VALID_OUT),
        .READY_OUT (READY_OUT),
        .LEVEL     (LEVEL),
        .BURST_CNT (BURST_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic int m_bursts();
        int c = 0;
        foreach (m_fifo[i]) if (m_fifo[i][0]) c++;
        return c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic chk_d(input string name, input logic [76:0] act, input logic [76:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock: drive inputs, predict the handshakes from the model, commit them after the edge.
    task automatic cycle(input logic v, input logic [76:0] d, input logic r, output logic acc);
        logic do_pop;
        VALID_IN  = v;
        DATA_IN   = d;
        READY_OUT = r;
        acc = v && (m_fifo.size() < DEPTH);
`ifdef WFIFO_STORE_FWD_EN
        do_pop = r && VALID_OUT;
`else
        do_pop = r && (m_fifo.size() != 0);
`endif
        if (acc) exp_q.push_back(d);
        @(posedge CLK);
        #1;
        if (do_pop) void'(m_fifo.pop_front());
        if (acc) m_fifo.push_back(d);
    endtask

    task automatic drain(input int budget);
        logic acc;
        int   n = 0;
        while (m_fifo.size() != 0 && n < budget) begin
            cycle(1'b0, '0, 1'b1, acc);
            n++;
        end
        if (m_fifo.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d beats left expected 0", m_fifo.size());
        end
    endtask

    function automatic logic [76:0] rand_beat(input logic last);
        logic [76:0] d;
        d = {13'($urandom), $urandom, $urandom};
        d[0] = last;
        return d;
    endfunction

    // Monitor: compare counters every cycle and score each beat the slave takes.
    initial begin
        logic [76:0] e;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                chk("level", int'(LEVEL), m_fifo.size());
                chk("burst_cnt", int'(BURST_CNT), m_bursts());
                chk("ready_in", int'(READY_IN), int'(m_fifo.size() < DEPTH));
`ifndef WFIFO_STORE_FWD_EN
                chk("valid_out", int'(VALID_OUT), int'(m_fifo.size() != 0));
`endif
                if (VALID_OUT && READY_OUT) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL sb_underflow: got %h expected no beat", DATA_OUT);
                    end else begin
                        e = exp_q.pop_front();
                        chk_d("data_out", DATA_OUT, e);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic saw_valid;
        int   acc_n;
        int   cyc;
        int   blen [3];

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_level", int'(LEVEL), 0);
        chk("rst_valid", int'(VALID_OUT), 0);
        chk("rst_ready", int'(READY_IN), 1);
        RESET = 1'b0;

        // Asynchronous reset with five beats resident.
        for (int i = 0; i < 5; i++) cycle(1'b1, rand_beat(1'(i == 2)), 1'b0, acc);
        chk("pre_rst_level", int'(LEVEL), 5);
        VALID_IN  = 1'b0;
        READY_OUT = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        chk("async_rst_level", int'(LEVEL), 0);
        chk("async_rst_burst", int'(BURST_CNT), 0);
        chk("async_rst_valid", int'(VALID_OUT), 0);
        chk("async_rst_ready", int'(READY_IN), 1);
        m_fifo.delete();
        exp_q.delete();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        cycle(1'b1, 77'h1A5, 1'b0, acc);
        chk("post_rst_valid", int'(VALID_OUT), 1);
        chk_d("post_rst_data", DATA_OUT, 77'h1A5);
        drain(20);

        // Fill to full, reject the 17th beat, then drain in order.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 77'(i), 1'b0, acc);
        chk("full_level", int'(LEVEL), DEPTH);
        chk("full_ready", int'(READY_IN), 0);
        cycle(1'b1, 77'd99, 1'b1, acc);
        chk("reject_when_full", int'(acc), 0);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1, acc);
        chk("drain_level", int'(LEVEL), 0);

        // Concurrent push/pop at level 8 across pointer wrap.
        for (int i = 0; i < 8; i++) cycle(1'b1, rand_beat(1'b1), 1'b0, acc);
        for (int i = 0; i < 40; i++) cycle(1'b1, rand_beat(1'b1), 1'b1, acc);
        chk("concurrent_level", int'(LEVEL), 8);
        drain(20);

        // Burst counting with lengths 1, 4, 3.
        blen = '{1, 4, 3};
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < blen[b]; k++) cycle(1'b1, rand_beat(1'(k == blen[b] - 1)), 1'b0, acc);
            cycle(1'b0, '0, 1'b0, acc);
            chk("burst_cnt_step", int'(BURST_CNT), b + 1);
        end
        cycle(1'b1, rand_beat(1'b1), 1'b1, acc);
        chk("last_push_pop_same", int'(BURST_CNT), 3);
        drain(30);
        chk("burst_cnt_drained", int'(BURST_CNT), 0);

`ifdef WFIFO_STORE_FWD_EN
        // Store-and-forward release on LAST, and fallback at full for an over-long burst.
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_beat(1'b0), 1'b1, acc);
        chk("sf_hold", int'(VALID_OUT), 0);
        cycle(1'b1, rand_beat(1'b1), 1'b1, acc);
        chk("sf_release", int'(VALID_OUT), 1);
        drain(20);
        acc_n     = 0;
        cyc       = 0;
        saw_valid = 1'b0;
        while (acc_n < 20 && cyc < 200) begin
            if (VALID_OUT) saw_valid = 1'b1;
            cycle(1'b1, rand_beat(1'(acc_n == 19)), 1'b1, acc);
            if (acc) acc_n++;
            cyc++;
        end
        chk("sf_long_accepted", acc_n, 20);
        chk("sf_long_cut_through", int'(saw_valid), 1);
        drain(40);
`endif

        // Random traffic.
        acc_n = 0;
        cyc   = 0;
        while (acc_n < 2000 && cyc < 20000) begin
            cycle(1'($urandom_range(0, 1)), rand_beat(1'($urandom_range(0, 3) == 0)),
                  1'($urandom_range(0, 1)), acc);
            if (acc) acc_n++;
            cyc++;
        end
        chk("random_accepted", acc_n, 2000);
        cyc = 0;
        acc = 1'b0;
        while (!acc && cyc < 100) begin
            cycle(1'b1, rand_beat(1'b1), 1'b1, acc);
            cyc++;
        end
        drain(200);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/w_burst_fifo.md
Name: w_burst_fifo

Overview:
- Buffers AXI4 write-data beats on the slave side, directly downstream of the two-master W-channel arbitration fabric.
- Accepts 77-bit W beats (bit 0 = LAST) from the fabric and presents them first-word-fall-through to the slave W port.
- Tracks occupancy and the number of complete bursts resident.
- Decouples slave back-pressure from the fabric, so the fabric's burst lock is released as soon as the LAST beat is accepted.

Parameters:
- DEPTH, 16, number of beat entries; power of two, minimum 2.
- AW, 4, log2(DEPTH); must equal log2(DEPTH).

Ports:
- CLK  input  1  single clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- DATA_IN  input  77  W beat: [76:13] WDATA, [12:5] WSTRB, [4:1] WUSER, [0] WLAST.
- VALID_IN  input  1  beat valid from the fabric.
- READY_IN  output  1  block can accept a beat.
- DATA_OUT  output  77  head beat, same layout as DATA_IN.
- VALID_OUT  output  1  head beat valid toward the slave.
- READY_OUT  input  1  slave accepts the head beat.
- LEVEL  output  AW+1  beats resident, 0..DEPTH.
- BURST_CNT  output  AW+1  resident beats with bit 0 = 1, i.e. complete bursts.

Behaviour:
- Storage and state
  - DEPTH x 77 register array, not reset.
  - Write pointer and read pointer are AW+1 bits each; the MSB is a wrap flag.
  - full = pointers differ only in MSB; empty = pointers equal.
- Handshakes
  - push = VALID_IN & READY_IN.
  - pop = VALID_OUT & READY_OUT.
  - READY_IN = !full, combinational from registered state only; it does not depend on VALID_IN or READY_OUT.
  - No push when full, even if a pop occurs in the same cycle.
  - VALID_OUT = !empty (default build).
  - DATA_OUT = array[rd_ptr[AW-1:0]], combinational read (FWFT).
  - DATA_OUT is don't-care when VALID_OUT = 0; the bench must not check it then.
- Latency
  - A beat pushed at edge N is visible on DATA_OUT/VALID_OUT after edge N when the block was empty: 1 cycle, with no bypass path.
  - Once VALID_OUT is high, DATA_OUT is held stable until pop.
- LEVEL
  - push only: +1. pop only: -1. Both or neither: unchanged.
  - Equals the wr_ptr − rd_ptr difference; pointers wrap modulo 2*DEPTH.
- BURST_CNT
  - +1 on a push with DATA_IN[0] = 1.
  - −1 on a pop with DATA_OUT[0] = 1.
  - Both in the same cycle: unchanged.
  - Never exceeds LEVEL.
- No state machine beyond the pointers and counters. The block does not check or repair burst structure; beats pass in order unmodified.
- Simultaneous push and pop:
  - When empty, only a push can occur.
  - When full, only a pop can occur.
  - Otherwise both complete in the same cycle.
- Reset
  - RESET = 1 clears both pointers, LEVEL and BURST_CNT immediately, without waiting for a clock edge.
  - During reset: READY_IN = 1, VALID_OUT = 0, LEVEL = 0, BURST_CNT = 0.
  - Reset in mid-burst discards all resident beats; no partial beat is emitted afterwards.
  - Reset deassertion is assumed synchronised externally.

Optional Feature:
- Macro: WFIFO_STORE_FWD_EN.
- Defined (store-and-forward):
  - VALID_OUT = !empty & ((BURST_CNT != 0) | full).
  - The slave therefore sees a burst only after its LAST beat is resident.
  - The full term prevents deadlock when a burst is longer than DEPTH; such bursts fall back to cut-through.
  - Once VALID_OUT rises for a burst, it stays high until the LAST beat is popped or LEVEL reaches 0.
- Not defined (cut-through): VALID_OUT = !empty, as above.
- READY_IN, LEVEL and BURST_CNT behave identically in both builds.

Test Plan:
1. Reset: assert RESET mid-cycle with LEVEL = 5 -> LEVEL = 0, BURST_CNT = 0, VALID_OUT = 0, READY_IN = 1 without a clock edge. The next push of 0x...A5 appears on DATA_OUT one cycle later.
2. Fill/drain: READY_OUT = 0, push 16 beats with data 0..15 -> READY_IN = 0 after the 16th push, LEVEL = 16. The 17th VALID_IN is not accepted. Then READY_OUT = 1 -> beats 0..15 come out in order, one per cycle, and LEVEL reaches 0.
3. Concurrent: hold LEVEL = 8, push and pop every cycle for 40 cycles (pointer wrap) -> LEVEL stays 8, output order matches input order, no loss or duplication.
4. Burst counting: push bursts of lengths 1, 4 and 3 (LAST on the final beat of each) -> BURST_CNT goes 1, 2, 3. Popping the LAST beats decrements it to 0. A simultaneous LAST push and LAST pop leaves it unchanged.
5. Store-and-forward (WFIFO_STORE_FWD_EN): push 3 non-LAST beats -> VALID_OUT = 0. After the 4th beat with LAST, VALID_OUT = 1 the next cycle. A 20-beat burst into DEPTH 16 asserts VALID_OUT at full and completes without deadlock.
6. Random: random VALID_IN/READY_OUT at 50 %, 2000 beats with random LAST -> scoreboard matches, and LEVEL/BURST_CNT match the reference-model counts every cycle.
